// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Fetch entries pair an instruction word with the PC+4 of the address it came from.
package ifu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitRsp,
    StDiscard
  } ifu_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus_four;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch entries with wrap-around pointers and a synchronous flush.
// The head entry is read straight from storage so the consumer sees it with no extra latency.
module fetch_queue
  import ifu_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  fetch_entry_t      push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output fetch_entry_t      head_o,
  output logic [CntW-1:0]   count_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));

  // Flush wins over both push and pop so nothing stale survives a redirect.
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while counted as valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: one outstanding request to instruction memory, a prefetch queue feeding IF/ID,
// hazard hold on the queue head and branch redirect that flushes and discards in-flight fetches.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned CNT_W    = $clog2(QDEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  output logic [31:0]      imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             fetch_hold,
  output logic             inst_valid,
  output logic [31:0]      inst_out,
  output logic [31:0]      inst_pc_plus_four,
  output logic [CNT_W-1:0] queue_count
);

  ifu_state_e   state_q, state_d;
  logic [31:0]  fpc_q, fpc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         active_q;

  logic         req_hs;
  logic         q_push, q_pop;
  logic         q_empty, q_full;
  fetch_entry_t q_head, q_push_data;
  logic [CNT_W-1:0] q_count;

  // ---------------------------------------------------------------------------
  // Prefetch queue
  // ---------------------------------------------------------------------------
  assign q_push_data.instr        = imem_rsp_data;
  assign q_push_data.pc_plus_four = req_pc_q + 32'd4;

  assign q_push = (state_q == StWaitRsp) & imem_rsp_valid & ~branch_taken;
  assign q_pop  = ~q_empty & ~fetch_hold & ~branch_taken;

  fetch_queue #(
    .Depth (QDEPTH),
    .CntW  (CNT_W)
  ) u_fetch_queue (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .push_i      (q_push),
    .push_data_i (q_push_data),
    .pop_i       (q_pop),
    .flush_i     (branch_taken),
    .head_o      (q_head),
    .count_o     (q_count),
    .empty_o     (q_empty),
    .full_o      (q_full)
  );

  assign req_hs = imem_req_valid & imem_req_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // A request accepted in the redirect cycle targets the old path.
        if (req_hs) state_d = branch_taken ? StDiscard : StWaitRsp;
      end
      StWaitRsp: begin
        if (imem_rsp_valid)    state_d = StIdle;
        else if (branch_taken) state_d = StDiscard;
      end
      StDiscard: begin
        if (imem_rsp_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req_valid    = active_q & (state_q == StIdle) & ~q_full;
    imem_req_addr     = fpc_q;
    inst_valid        = ~q_empty;
    inst_out          = q_empty ? NOP_INSTR : q_head.instr;
    inst_pc_plus_four = q_empty ? 32'h0 : q_head.pc_plus_four;
    queue_count       = q_count;
  end

  // ---------------------------------------------------------------------------
  // Fetch PC and in-flight request PC
  // ---------------------------------------------------------------------------
  always_comb begin
    fpc_d    = fpc_q;
    req_pc_d = req_pc_q;
    if (req_hs) req_pc_d = fpc_q;
    if (branch_taken) begin
      fpc_d = align_word(branch_target);
    end else if (req_hs) begin
      fpc_d = fpc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q    <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      fpc_q    <= fpc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Keeps the request line low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a memory model plus a stream-level reference (sequential
// PCs since the last redirect) checks every delivered instruction, request address and count.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned QDEPTH   = 4;
  localparam int unsigned CNT_W    = $clog2(QDEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             imem_req_valid;
  logic [31:0]      imem_req_addr;
  logic             imem_req_ready;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_data;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             fetch_hold;
  logic             inst_valid;
  logic [31:0]      inst_out;
  logic [31:0]      inst_pc_plus_four;
  logic [CNT_W-1:0] queue_count;

  instruction_fetch_unit #(
    .RESET_PC (RESET_PC),
    .QDEPTH   (QDEPTH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .imem_req_valid    (imem_req_valid),
    .imem_req_addr     (imem_req_addr),
    .imem_req_ready    (imem_req_ready),
    .imem_rsp_valid    (imem_rsp_valid),
    .imem_rsp_data     (imem_rsp_data),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .fetch_hold        (fetch_hold),
    .inst_valid        (inst_valid),
    .inst_out          (inst_out),
    .inst_pc_plus_four (inst_pc_plus_four),
    .queue_count       (queue_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Stimulus knobs
  int          p_ready, p_hold, p_branch, lat_max;
  logic        next_branch;
  logic [31:0] next_target;
  logic        arm_rsp_branch, armed_fired;

  // Reference model
  logic        pend, stale;
  logic [31:0] pend_addr;
  int          pend_lat;
  logic [31:0] exp_addr, pc_exp;
  int          exp_count, pops;
  logic        wrap_seen;
  logic        prev_rv, prev_ready, prev_branch;
  logic [31:0] prev_addr;

  // Samples taken at the falling edge
  logic             s_rv, s_iv;
  logic [31:0]      s_addr, s_io, s_ppf;
  logic [CNT_W-1:0] s_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic model_reset();
    pend = 1'b0; stale = 1'b0; pend_addr = '0; pend_lat = 0;
    exp_addr = RESET_PC; pc_exp = RESET_PC; exp_count = 0;
    prev_rv = 1'b0; prev_ready = 1'b0; prev_branch = 1'b0; prev_addr = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    branch_taken = 1'b0; branch_target = '0; fetch_hold = 1'b0;
  endtask

  // One clock cycle: sample and check at the falling edge, then drive inputs for the next
  // rising edge and advance the model by what that edge will do.
  task automatic step();
    logic        hold, ready, rsp_now, br, hs, pop, push;
    logic [31:0] tgt, r;
    @(negedge clk);
    s_rv = imem_req_valid; s_addr = imem_req_addr; s_iv = inst_valid;
    s_io = inst_out; s_ppf = inst_pc_plus_four; s_cnt = queue_count;

    chk("queue_count", 32'(s_cnt), exp_count);
    chk("inst_valid", 32'(s_iv), 32'(exp_count != 0));
    if (!s_iv) begin
      chk("empty_inst_out", s_io, 32'h0);
      chk("empty_pc_plus_four", s_ppf, 32'h0);
    end
    if (pend || exp_count == QDEPTH) chk("req_valid_low", 32'(s_rv), 32'd0);
    if (s_rv) chk("req_addr", s_addr, exp_addr);
    if (prev_rv && !prev_ready && !prev_branch) begin
      chk("req_valid_stable", 32'(s_rv), 32'd1);
      chk("req_addr_stable", s_addr, prev_addr);
    end

    hold    = ($urandom_range(99) < p_hold);
    ready   = ($urandom_range(99) < p_ready);
    rsp_now = pend && (pend_lat == 0);
    br      = next_branch || ($urandom_range(99) < p_branch);
    tgt     = next_target;
    if (!next_branch) begin
      r = $urandom;
      tgt = ($urandom_range(3) == 0) ? (32'hffff_fff0 | {28'h0, r[3:0]}) : r;
    end
    if (arm_rsp_branch && rsp_now && !stale && s_iv && !hold) begin
      br = 1'b1; arm_rsp_branch = 1'b0; armed_fired = 1'b1;
    end
    next_branch = 1'b0;

    fetch_hold     = hold;
    imem_req_ready = ready;
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(pend_addr) : $urandom;
    branch_taken   = br;
    branch_target  = tgt;

    hs   = s_rv && ready;
    pop  = s_iv && !hold && !br;
    push = rsp_now && !stale && !br;
    if (pop) begin
      chk("inst_out", s_io, mem_word(pc_exp));
      chk("inst_pc_plus_four", s_ppf, pc_exp + 32'd4);
      if (pc_exp == 32'hffff_fffc) wrap_seen = 1'b1;
      pc_exp = pc_exp + 32'd4;
      pops++;
    end
    exp_count = br ? 0 : exp_count + int'(push) - int'(pop);
    if (rsp_now) pend = 1'b0;
    else if (pend) pend_lat--;
    if (br && pend) stale = 1'b1;
    if (hs) begin
      pend = 1'b1; pend_addr = s_addr; pend_lat = $urandom_range(lat_max); stale = br;
    end
    if (br) begin
      exp_addr = tgt & ~32'h3;
      pc_exp   = exp_addr;
    end else if (hs) begin
      exp_addr = exp_addr + 32'd4;
    end
    prev_rv = s_rv; prev_addr = s_addr; prev_ready = ready; prev_branch = br;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst_out"}, inst_out, 32'h0);
    chk({tag, "_pc_plus_four"}, inst_pc_plus_four, 32'h0);
    chk({tag, "_count"}, 32'(queue_count), 32'd0);
  endtask

  initial begin
    logic [31:0] held_io, a0;
    logic        held_set;
    int          n;

    next_branch = 1'b0; next_target = '0; arm_rsp_branch = 1'b0; armed_fired = 1'b0;
    pops = 0; wrap_seen = 1'b0;
    model_reset();

    // Reset
    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Straight-line fetch, always-ready single-cycle memory
    p_ready = 100; p_hold = 0; p_branch = 0; lat_max = 0;
    for (int i = 0; i < 12; i++) step();
    chk("pops_after_streaming", 32'(pops >= 3), 32'd1);

    // Hold: queue fills to QDEPTH, head stays put
    p_hold = 100; held_set = 1'b0; held_io = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_iv && held_set) chk("hold_inst_stable", s_io, held_io);
      if (s_iv && !held_set) begin held_io = s_io; held_set = 1'b1; end
    end
    chk("hold_full_count", 32'(s_cnt), QDEPTH);
    chk("hold_full_req_low", 32'(s_rv), 32'd0);
    p_hold = 0;
    for (int i = 0; i < 8; i++) step();

    // Redirect while a response is outstanding
    lat_max = 3; n = 0;
    while (!(pend && !stale && pend_lat > 0) && n < 50) begin step(); n++; end
    chk("reach_wait_rsp", 32'(pend && !stale && pend_lat > 0), 32'd1);
    next_branch = 1'b1; next_target = 32'h0000_0103;
    step();
    n = 0;
    do begin step(); n++; end while (!s_rv && n < 20);
    chk("redirect_req_addr", s_addr, 32'h0000_0100);
    chk("redirect_inst_valid", 32'(s_iv), 32'd0);
    for (int i = 0; i < 10; i++) step();

    // Redirect coinciding with a response and a pop
    p_hold = 100; lat_max = 0;
    for (int i = 0; i < 12; i++) step();
    p_hold = 0; arm_rsp_branch = 1'b1; armed_fired = 1'b0; n = 0;
    while (!armed_fired && n < 60) begin step(); n++; end
    chk("rsp_branch_fired", 32'(armed_fired), 32'd1);
    arm_rsp_branch = 1'b0;
    step();
    chk("rsp_branch_count_zero", 32'(s_cnt), 32'd0);
    for (int i = 0; i < 6; i++) step();

    // Memory not ready: request must hold steady
    p_ready = 0; n = 0;
    do begin step(); n++; end while (!s_rv && n < 10);
    a0 = s_addr;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_req_valid", 32'(s_rv), 32'd1);
      chk("stall_req_addr", s_addr, a0);
    end
    p_ready = 100;

    // Asynchronous reset while waiting on a response
    lat_max = 3; n = 0;
    while (!(pend && !stale && pend_lat > 0) && n < 50) begin step(); n++; end
    chk("reach_wait_rsp_reset", 32'(pend && !stale && pend_lat > 0), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    check_reset_outputs("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    lat_max = 0;
    for (int i = 0; i < 8; i++) step();

    // Wrap of the fetch PC past the top of the address space
    next_branch = 1'b1; next_target = 32'hffff_fffc; wrap_seen = 1'b0;
    for (int i = 0; i < 16; i++) step();
    chk("wrap_entry_seen", 32'(wrap_seen), 32'd1);

    // Randomised traffic
    p_ready = 70; p_hold = 30; p_branch = 3; lat_max = 3;
    for (int i = 0; i < 3000; i++) step();
    p_branch = 0; p_hold = 0;
    for (int i = 0; i < 20; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front-end fetch engine that sits directly upstream of the IF/ID pipeline register. It replaces the single-cycle PC/instruction-memory path with a request/response instruction-memory interface and a small prefetch queue. It supplies {instruction, PC+4} pairs to IF/ID, honours hazard-unit hold, and redirects on taken branches, discarding stale fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (word-aligned)
QDEPTH, 4, prefetch queue entries (power of two, 2..8)
CNT_W, $clog2(QDEPTH+1), width of occupancy count

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  32  fetch word address
imem_req_ready  input  1  memory accepts request this cycle
imem_rsp_valid  input  1  response data valid (1-cycle pulse, in order)
imem_rsp_data  input  32  instruction word
branch_taken  input  1  redirect pulse from branch resolution
branch_target  input  32  redirect address
fetch_hold  input  1  hazard-unit stall; do not pop queue
inst_valid  output  1  queue head valid
inst_out  output  32  queue head instruction (32'h0 NOP when empty)
inst_pc_plus_four  output  32  queue head PC+4 (32'h0 when empty)
queue_count  output  CNT_W  current occupancy

Behaviour:
- Reset (rst_n=0, async): fpc=RESET_PC, queue empty, state IDLE, queue_count=0, inst_valid=0, inst_out=0, inst_pc_plus_four=0, imem_req_valid=0 while rst_n low.
- One outstanding request max. States: IDLE, WAIT_RSP, DISCARD.
- IDLE: imem_req_valid=1 iff queue_count < QDEPTH; imem_req_addr=fpc. On valid&ready: fpc<=fpc+4, save req_pc=fpc, -> WAIT_RSP.
- WAIT_RSP: imem_req_valid=0. On imem_rsp_valid: push {imem_rsp_data, req_pc+4}, -> IDLE. Space is guaranteed (count checked at issue, pops only reduce).
- DISCARD: imem_req_valid=0. On imem_rsp_valid: drop data, -> IDLE.
- Request stability: once raised, imem_req_valid/addr hold until accepted, except a branch redirect may change addr the following cycle.
- Pop: when inst_valid & !fetch_hold at clock edge, head removed. Push and pop same cycle: count unchanged, both take effect.
- Output is head entry straight from queue storage (0-cycle read); first instruction after reset visible no earlier than 2 cycles after rst_n release with single-cycle memory.
- Branch redirect (branch_taken=1), highest priority: queue flushed (count=0, inst_valid=0 next cycle), no pop that cycle, fpc<=branch_target with bits[1:0] forced 0.
  - In IDLE with request handshake same cycle: stale request accepted -> DISCARD.
  - In IDLE without handshake: stay IDLE.
  - In WAIT_RSP without rsp_valid: -> DISCARD.
  - In WAIT_RSP with rsp_valid same cycle: response dropped, -> IDLE.
  - In DISCARD: stay DISCARD (or -> IDLE if rsp_valid same cycle); fpc updated.
- fpc wraps modulo 2^32 (32'hFFFF_FFFC+4=0); PC+4 likewise.
- fetch_hold with empty queue: no effect; fetching continues until full.

Decomposition:
- Shared package ifu_pkg: state enum {IDLE, WAIT_RSP, DISCARD}, constant NOP_INSTR=32'h0, typedef fetch_entry_t {instr[31:0], pc_plus_four[31:0]}.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, QDEPTH entries, push/pop/flush, wrap-around pointers, count output, async active-low reset. Top holds FSM, fpc, req_pc.

Test Plan:
- Reset then ready=1, 1-cycle rsp, hold=0 -> addrs 0,4,8 issued; inst_out sequence mem[0],mem[1],mem[2] with pc_plus_four 4,8,12.
- hold=1 for 10 cycles -> queue_count saturates at 4, imem_req_valid=0 when full, inst_out stable; release -> 4 entries pop in order, no loss.
- branch_taken=1, target=32'h0000_0103 while in WAIT_RSP -> stale response dropped, next req addr 32'h0000_0100, inst_valid=0 until its response.
- Branch in same cycle as rsp_valid and same cycle as a pop -> response not queued, count=0 next cycle, next addr=target.
- imem_req_ready held 0 for 5 cycles -> req_valid/addr stable; rst_n pulled low mid-WAIT_RSP -> all outputs reset immediately, restart fetch from RESET_PC.
- fpc=32'hFFFF_FFFC -> following request addr 32'h0, entry pc_plus_four 32'h0.
